baud_gen_frac: RTL and testbench

Programmable fractional-N baud tick generator, the successor to the fixed-divisor UART tick source. The divisor is loaded at run time as an integer part plus a binary fraction, and a phase accumulator dithers the tick period so the average rate matches the target. Example: 50 MHz / 19200 / 16 = 162.76 is programmed as 162 + 12/16. It feeds the UART RX/TX oversampling tick input and optionally provides bit-rate and mid-bit strobes.

---
 rtl/baud_gen_pkg.sv | 27 ++
 rtl/baud_bit_phase.sv | 45 ++++
 rtl/baud_gen_frac.sv | 134 +++++++++++++
 tb/tb_baud_gen_frac.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/baud_gen_pkg.sv
// Shared constants, types and helpers for the fractional baud tick generator.
//   MIN_DIV_INT  : smallest usable integer divisor; smaller values are clamped
//   DIV_INT_W    : storage width of the integer divisor field
//   DIV_FRAC_W   : storage width of the fractional divisor field
//   baud_div_t   : {integer, fraction} divisor pair
//   clog2_w()    : ceil(log2(n)), never less than 1
package baud_gen_pkg;

  localparam int unsigned MIN_DIV_INT = 2;
  localparam int unsigned DIV_INT_W   = 16;
  localparam int unsigned DIV_FRAC_W  = 4;

  typedef struct packed {
    logic [DIV_INT_W-1:0]  div_int;
    logic [DIV_FRAC_W-1:0] div_frac;
  } baud_div_t;

  function automatic int unsigned clog2_w(input int unsigned value);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/baud_bit_phase.sv
// Bit-phase tracker: counts sample ticks within a bit and decodes the
// bit-boundary and mid-bit strobes.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_tick         : oversampling tick from the divider
//   i_sync         : restart bit phase (sample counter to zero next cycle)
//   o_bit_tick     : tick on the last sample of a bit
//   o_mid_tick     : tick on the mid-bit sample
module baud_bit_phase
  import baud_gen_pkg::*;
#(
  parameter int unsigned OVERSAMPLING = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tick,
  input  logic i_sync,
  output logic o_bit_tick,
  output logic o_mid_tick
);

  localparam int unsigned NB_S = clog2_w(OVERSAMPLING);

  logic [NB_S-1:0] r_scnt;
  logic            w_last;
  logic            w_mid;

  assign w_last = (r_scnt == NB_S'(OVERSAMPLING - 1));
  assign w_mid  = (r_scnt == NB_S'(OVERSAMPLING / 2 - 1));

  // Sync overrides a coincident tick, so no strobe is emitted that cycle.
  assign o_bit_tick = i_tick && !i_sync && w_last;
  assign o_mid_tick = i_tick && !i_sync && w_mid;

  // Sample counter within the current bit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_scnt <= '0;
    end else if (i_sync) begin
      r_scnt <= '0;
    end else if (i_tick) begin
      r_scnt <= w_last ? '0 : r_scnt + NB_S'(1);
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional-N baud tick generator. A cycle counter runs to div_int (+1 when
// the fractional accumulator carries) so the average tick period equals
// div_int + div_frac / 2^NB_FRAC. New divisors are staged in a shadow
// register and applied on a period boundary.
// Optional feature macro: BAUD_GEN_BIT_TICK_EN adds i_bit_sync, o_bit_tick
// and o_mid_tick through the baud_bit_phase sub-module.
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_enable                : count enable; all counting holds while low
//   i_div_int, i_div_frac   : divisor captured by i_div_load
//   i_div_load              : strobe writing the shadow divisor
//   o_div_pending           : shadow divisor waiting to be applied
//   o_tick                  : one-cycle oversampling tick
//   i_bit_sync/o_bit_tick/o_mid_tick : bit phase control and strobes
module baud_gen_frac
  import baud_gen_pkg::*;
#(
  parameter int unsigned NB_INT           = 16,
  parameter int unsigned NB_FRAC          = 4,
  parameter int unsigned OVERSAMPLING     = 16,
  parameter int unsigned DEFAULT_DIV_INT  = 162,
  parameter int unsigned DEFAULT_DIV_FRAC = 12
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [NB_INT-1:0]  i_div_int,
  input  logic [NB_FRAC-1:0] i_div_frac,
  input  logic               i_div_load,
  output logic               o_div_pending,
`ifdef BAUD_GEN_BIT_TICK_EN
  input  logic               i_bit_sync,
  output logic               o_bit_tick,
  output logic               o_mid_tick,
`endif
  output logic               o_tick
);

  localparam int unsigned NB_LIM = NB_INT + 1;

  localparam baud_div_t DEFAULT_DIV = '{
    div_int:  DIV_INT_W'(DEFAULT_DIV_INT),
    div_frac: DIV_FRAC_W'(DEFAULT_DIV_FRAC)
  };

  baud_div_t          r_active;
  baud_div_t          r_shadow;
  logic               r_pending;
  logic [NB_INT-1:0]  r_cnt;
  logic [NB_FRAC-1:0] r_acc;
  logic               r_carry;

  logic [NB_INT-1:0]  w_div_int;
  logic [NB_FRAC-1:0] w_div_frac;
  logic [NB_INT-1:0]  w_div_clamped;
  logic [NB_LIM-1:0]  w_lim_m1;
  logic [NB_FRAC:0]   w_sum;
  logic               w_tick;
  logic               w_sync;
  logic               w_apply;

`ifdef BAUD_GEN_BIT_TICK_EN
  assign w_sync = i_bit_sync;
`else
  assign w_sync = 1'b0;
`endif

  assign w_div_int     = NB_INT'(r_active.div_int);
  assign w_div_frac    = NB_FRAC'(r_active.div_frac);
  assign w_div_clamped = (w_div_int < NB_INT'(MIN_DIV_INT)) ? NB_INT'(MIN_DIV_INT) : w_div_int;

  // Last count of the current period: clamped divisor plus carry, minus one.
  assign w_lim_m1 = NB_LIM'(w_div_clamped) + NB_LIM'(r_carry) - NB_LIM'(1);
  assign w_tick   = i_enable && (NB_LIM'(r_cnt) == w_lim_m1);
  assign w_sum    = NB_FRAC'(r_acc) + (NB_FRAC + 1)'(w_div_frac);

  // Pending divisor goes live on a real period end, or at once when idle.
  assign w_apply = r_pending && ((w_tick && !w_sync) || !i_enable);

  assign o_tick        = w_tick;
  assign o_div_pending = r_pending;

  // Divisor staging and period counting.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_active  <= DEFAULT_DIV;
      r_shadow  <= DEFAULT_DIV;
      r_pending <= 1'b0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_carry   <= 1'b0;
    end else begin
      if (i_div_load) begin
        r_shadow.div_int  <= DIV_INT_W'(i_div_int);
        r_shadow.div_frac <= DIV_FRAC_W'(i_div_frac);
      end

      // A load in the apply cycle stages the next divisor, so it keeps pending.
      if (i_div_load) begin
        r_pending <= 1'b1;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end

      if (w_apply) begin
        r_active <= r_shadow;
        r_cnt    <= '0;
        r_acc    <= '0;
        r_carry  <= 1'b0;
      end else if (w_sync) begin
        r_cnt <= '0;
      end else if (w_tick) begin
        r_cnt   <= '0;
        r_acc   <= w_sum[NB_FRAC-1:0];
        r_carry <= w_sum[NB_FRAC];
      end else if (i_enable) begin
        r_cnt <= r_cnt + NB_INT'(1);
      end
    end
  end

`ifdef BAUD_GEN_BIT_TICK_EN
  baud_bit_phase #(
    .OVERSAMPLING (OVERSAMPLING)
  ) u_bit_phase (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_tick     (w_tick),
    .i_sync     (w_sync),
    .o_bit_tick (o_bit_tick),
    .o_mid_tick (o_mid_tick)
  );
`endif

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac with a 4.0 default divisor and
// OVERSAMPLING = 4. Bit-phase checks are built only with BAUD_GEN_BIT_TICK_EN.
module tb_baud_gen_frac;

  localparam int unsigned NB_INT  = 16;
  localparam int unsigned NB_FRAC = 4;

  logic               clk;
  logic               i_reset;
  logic               i_enable;
  logic [NB_INT-1:0]  i_div_int;
  logic [NB_FRAC-1:0] i_div_frac;
  logic               i_div_load;
  logic               o_div_pending;
  logic               o_tick;
`ifdef BAUD_GEN_BIT_TICK_EN
  logic               i_bit_sync;
  logic               o_bit_tick;
  logic               o_mid_tick;
`endif

  int checks   = 0;
  int failures = 0;

  baud_gen_frac #(
    .NB_INT           (NB_INT),
    .NB_FRAC          (NB_FRAC),
    .OVERSAMPLING     (4),
    .DEFAULT_DIV_INT  (4),
    .DEFAULT_DIV_FRAC (0)
  ) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_enable      (i_enable),
    .i_div_int     (i_div_int),
    .i_div_frac    (i_div_frac),
    .i_div_load    (i_div_load),
    .o_div_pending (o_div_pending),
`ifdef BAUD_GEN_BIT_TICK_EN
    .i_bit_sync    (i_bit_sync),
    .o_bit_tick    (o_bit_tick),
    .o_mid_tick    (o_mid_tick),
`endif
    .o_tick        (o_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Cycles from the current cycle to the next o_tick (bounded).
  task automatic next_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (o_tick !== 1'b1 && n < 200);
  endtask

  task automatic load(input int unsigned di, input int unsigned df);
    i_div_int  = NB_INT'(di);
    i_div_frac = NB_FRAC'(df);
    i_div_load = 1'b1;
  endtask

  int n;
  int total;
  int exp_per [17] = '{4, 4, 5, 4, 5, 4, 5, 4, 5, 4, 5, 4, 5, 4, 5, 4, 5};

  initial begin
    i_reset    = 1'b1;
    i_enable   = 1'b1;
    i_div_int  = '0;
    i_div_frac = '0;
    i_div_load = 1'b0;
`ifdef BAUD_GEN_BIT_TICK_EN
    i_bit_sync = 1'b0;
`endif
    step();
    step();
    chk("reset_tick", 32'(o_tick), 32'd0);
    chk("reset_pending", 32'(o_div_pending), 32'd0);
`ifdef BAUD_GEN_BIT_TICK_EN
    chk("reset_bit", 32'(o_bit_tick), 32'd0);
    chk("reset_mid", 32'(o_mid_tick), 32'd0);
`endif
    i_reset = 1'b0;

    // Default 4.0: ticks at cycles 3, 7, 11.
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("default_tick_c%0d", c), 32'(o_tick), 32'((c % 4) == 3));
      chk($sformatf("default_pending_c%0d", c), 32'(o_div_pending), 32'd0);
      if (c < 11) step();
    end

    // Load 4.5 coincident with a tick: applies at the following tick.
    load(4, 8);
    step();
    i_div_load = 1'b0;
    chk("frac_pending_rise", 32'(o_div_pending), 32'd1);
    next_tick(n);
    chk("frac_old_period", 32'(n + 1), 32'd4);
    chk("frac_pending_at_apply", 32'(o_div_pending), 32'd1);
    total = 0;
    for (int p = 0; p < 17; p++) begin
      next_tick(n);
      chk($sformatf("frac_period_%0d", p + 1), 32'(n), 32'(exp_per[p]));
      if (p > 0) total += n;
    end
    chk("frac_pending_clear", 32'(o_div_pending), 32'd0);
    chk("frac_16_span", 32'(total), 32'd72);

    // Load 5.0 then 6.0 inside a 4-cycle period; last load wins at the tick.
    step();
    load(5, 0);
    step();
    load(6, 0);
    step();
    i_div_load = 1'b0;
    next_tick(n);
    chk("lastwin_old_period", 32'(n + 3), 32'd4);
    chk("lastwin_pending_at_tick", 32'(o_div_pending), 32'd1);
    step();
    chk("lastwin_pending_clear", 32'(o_div_pending), 32'd0);
    chk("lastwin_no_tick", 32'(o_tick), 32'd0);
    next_tick(n);
    chk("lastwin_period1", 32'(n + 1), 32'd6);
    next_tick(n);
    chk("lastwin_period2", 32'(n), 32'd6);

    // Enable low for 10 cycles mid-period stretches it by exactly 10.
    step();
    step();
    i_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold_no_tick_%0d", i), 32'(o_tick), 32'd0);
      step();
    end
    i_enable = 1'b1;
    next_tick(n);
    chk("hold_period", 32'(n + 12), 32'd16);

    // Divisor 0 clamps to 2.
    load(0, 0);
    step();
    i_div_load = 1'b0;
    next_tick(n);
    chk("div0_old_period", 32'(n + 1), 32'd6);
    next_tick(n);
    chk("div0_period1", 32'(n), 32'd2);
    next_tick(n);
    chk("div0_period2", 32'(n), 32'd2);

    // Divisor 1 clamps to 2.
    load(1, 0);
    step();
    i_div_load = 1'b0;
    next_tick(n);
    chk("div1_apply_period", 32'(n + 1), 32'd2);
    next_tick(n);
    chk("div1_period1", 32'(n), 32'd2);
    chk("div1_pending", 32'(o_div_pending), 32'd0);

    // Reset while pending discards the staged divisor.
    step();
    load(9, 3);
    step();
    i_div_load = 1'b0;
    chk("rst_pending_before", 32'(o_div_pending), 32'd1);
    i_reset = 1'b1;
    step();
    chk("rst_pending_after", 32'(o_div_pending), 32'd0);
    chk("rst_tick_after", 32'(o_tick), 32'd0);
    i_reset = 1'b0;
    next_tick(n);
    chk("rst_first_tick", 32'(n), 32'd3);
    next_tick(n);
    chk("rst_default_period", 32'(n), 32'd4);

    // Pending divisor applies the cycle after it is seen with enable low.
    step();
    i_enable = 1'b0;
    load(3, 0);
    step();
    i_div_load = 1'b0;
    chk("idle_pending_set", 32'(o_div_pending), 32'd1);
    step();
    chk("idle_pending_applied", 32'(o_div_pending), 32'd0);
    i_enable = 1'b1;
    next_tick(n);
    chk("idle_first_period", 32'(n), 32'd2);
    next_tick(n);
    chk("idle_period", 32'(n), 32'd3);

`ifdef BAUD_GEN_BIT_TICK_EN
    // Sync coincident with a tick: no strobes, then mid at +6, bit at +12.
    begin
      int first_mid;
      int first_bit;
      int mid_cnt;
      first_mid  = 0;
      first_bit  = 0;
      i_bit_sync = 1'b1;
      chk("sync_no_bit", 32'(o_bit_tick), 32'd0);
      chk("sync_no_mid", 32'(o_mid_tick), 32'd0);
      for (int k = 1; k <= 12; k++) begin
        step();
        i_bit_sync = 1'b0;
        if (o_mid_tick === 1'b1 && first_mid == 0) first_mid = k;
        if (o_bit_tick === 1'b1 && first_bit == 0) first_bit = k;
      end
      chk("sync_mid_delay", 32'(first_mid), 32'd6);
      chk("sync_bit_delay", 32'(first_bit), 32'd12);
      first_mid = 0;
      first_bit = 0;
      mid_cnt   = 0;
      for (int k = 1; k <= 12; k++) begin
        step();
        if (o_mid_tick === 1'b1) begin
          mid_cnt++;
          if (first_mid == 0) first_mid = k;
        end
        if (o_bit_tick === 1'b1 && first_bit == 0) first_bit = k;
      end
      chk("bit_to_mid", 32'(first_mid), 32'd6);
      chk("bit_to_bit", 32'(first_bit), 32'd12);
      chk("mid_per_bit", 32'(mid_cnt), 32'd1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
